// File: rtl/traffic_phase_sequencer.sv
// rtl/traffic_phase_sequencer.sv - NS/EW intersection phase sequencer with ped service and night flash
// Phase timing is driven by the rising edge of a 1 Hz square wave; all lamp outputs are Moore decodes.
module traffic_phase_sequencer #(
  parameter int GREEN_MIN   = 10,
  parameter int EW_GREEN    = 8,
  parameter int YELLOW_TIME = 3,
  parameter int ALLRED_TIME = 2,
  parameter int WALK_TIME   = 6
) (
  input  logic       clk,
  input  logic       Reset_n,
  input  logic       OneHz,
  input  logic       EW_Sensor,
  input  logic       Ped_Req,
  input  logic       Night_Mode,
  output logic [2:0] NS_Light,
  output logic [2:0] EW_Light,
  output logic       Walk,
  output logic       Ped_Ack,
  output logic [7:0] Seconds_Left
);

  typedef enum logic [3:0] {
    S_ALL_RED   = 4'd0,
    S_NS_GREEN  = 4'd1,
    S_NS_YELLOW = 4'd2,
    S_CLEAR1    = 4'd3,
    S_EW_GREEN  = 4'd4,
    S_EW_YELLOW = 4'd5,
    S_PED_WALK  = 4'd6,
    S_CLEAR2    = 4'd7,
    S_FLASH     = 4'd8
  } state_t;

  localparam logic [7:0] D_GREEN_MIN = 8'(GREEN_MIN);
  localparam logic [7:0] D_EW_GREEN  = 8'(EW_GREEN);
  localparam logic [7:0] D_YELLOW    = 8'(YELLOW_TIME);
  localparam logic [7:0] D_ALLRED    = 8'(ALLRED_TIME);
  localparam logic [7:0] D_WALK      = 8'(WALK_TIME);

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;
  localparam logic [2:0] LAMP_OFF    = 3'b000;

  state_t     r_state;
  state_t     w_next;
  logic       r_one_d;
  logic       r_flash;
  logic       r_ew_pend;
  logic       r_ped_pend;
  logic [7:0] r_secs;
  logic [7:0] w_load;
  logic       w_tick;
  logic       w_enter;
  logic       w_last;
  logic       w_min_done;
  logic       w_clr_ew;
  logic       w_clr_ped;

  assign w_tick     = OneHz & ~r_one_d;
  assign w_enter    = (w_next != r_state);
  assign w_last     = (r_secs == 8'd1);
  assign w_min_done = (r_secs <= 8'd1);
  // Clear has priority over a same-cycle set on both demand latches.
  assign w_clr_ew   = w_enter && (w_next == S_EW_GREEN);
  assign w_clr_ped  = w_enter && (w_next == S_PED_WALK);

  always_comb begin
    w_load = 8'd0;
    case (w_next)
      S_ALL_RED:   w_load = D_ALLRED;
      S_NS_GREEN:  w_load = D_GREEN_MIN;
      S_NS_YELLOW: w_load = D_YELLOW;
      S_CLEAR1:    w_load = D_ALLRED;
      S_EW_GREEN:  w_load = D_EW_GREEN;
      S_EW_YELLOW: w_load = D_YELLOW;
      S_PED_WALK:  w_load = D_WALK;
      S_CLEAR2:    w_load = D_ALLRED;
      default:     w_load = 8'd0;
    endcase
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state    <= S_ALL_RED;
      r_secs     <= D_ALLRED;
      r_one_d    <= 1'b1;
      r_flash    <= 1'b0;
      r_ew_pend  <= 1'b0;
      r_ped_pend <= 1'b0;
    end else begin
      r_one_d <= OneHz;
      r_state <= w_next;

      if (w_enter) begin
        r_secs <= w_load;
      end else if (w_tick && (r_secs != 8'd0)) begin
        r_secs <= r_secs - 8'd1;
      end

      if (w_enter && (w_next == S_FLASH)) begin
        r_flash <= 1'b0;
      end else if (w_tick && (r_state == S_FLASH)) begin
        r_flash <= ~r_flash;
      end

      r_ew_pend  <= w_clr_ew  ? 1'b0 : (r_ew_pend  | EW_Sensor);
      r_ped_pend <= w_clr_ped ? 1'b0 : (r_ped_pend | Ped_Req);
    end
  end

  always_comb begin
    w_next = r_state;
    if (w_tick) begin
      case (r_state)
        S_ALL_RED:   if (w_last) w_next = S_NS_GREEN;
        S_NS_GREEN: begin
          // Green rests here once the minimum has run out and nothing is waiting.
          if (w_min_done) begin
            if (Night_Mode)                    w_next = S_FLASH;
            else if (r_ped_pend || r_ew_pend)  w_next = S_NS_YELLOW;
          end
        end
        S_NS_YELLOW: if (w_last) w_next = S_CLEAR1;
        S_CLEAR1: begin
          if (w_last) begin
            if (r_ped_pend)     w_next = S_PED_WALK;
            else if (r_ew_pend) w_next = S_EW_GREEN;
            else                w_next = S_NS_GREEN;
          end
        end
        S_EW_GREEN:  if (w_last) w_next = S_EW_YELLOW;
        S_EW_YELLOW: if (w_last) w_next = S_CLEAR2;
        S_PED_WALK:  if (w_last) w_next = S_CLEAR2;
        S_CLEAR2:    if (w_last) w_next = S_NS_GREEN;
        S_FLASH:     if (!Night_Mode) w_next = S_ALL_RED;
        default:     w_next = S_ALL_RED;
      endcase
    end
  end

  always_comb begin
    NS_Light     = LAMP_RED;
    EW_Light     = LAMP_RED;
    Walk         = 1'b0;
    Ped_Ack      = r_ped_pend;
    Seconds_Left = r_secs;
    case (r_state)
      S_NS_GREEN:  NS_Light = LAMP_GREEN;
      S_NS_YELLOW: NS_Light = LAMP_YELLOW;
      S_EW_GREEN:  EW_Light = LAMP_GREEN;
      S_EW_YELLOW: EW_Light = LAMP_YELLOW;
      S_PED_WALK:  Walk     = 1'b1;
      S_FLASH: begin
        NS_Light = r_flash ? LAMP_YELLOW : LAMP_OFF;
        EW_Light = r_flash ? LAMP_RED    : LAMP_OFF;
      end
      default: begin
        NS_Light = LAMP_RED;
        EW_Light = LAMP_RED;
      end
    endcase
  end

endmodule

// File: doc/traffic_phase_sequencer.md
Name: traffic_phase_sequencer

Overview:
- Intersection phase controller for a main road (NS) and a side road (EW), with pedestrian service and night flashing mode.
- Consumes the 1 Hz square wave from the clock divider. Detects its rising edge as a one-second tick. Sequences the light phases from per-phase durations.
- Drives the lamp outputs and a seconds-remaining count for the display block.

Parameters:
- GREEN_MIN, 10, minimum NS green in ticks before demand is served (1..255)
- EW_GREEN, 8, EW green duration in ticks (1..255)
- YELLOW_TIME, 3, yellow duration in ticks for either road (1..255)
- ALLRED_TIME, 2, all-red clearance duration in ticks (1..255)
- WALK_TIME, 6, pedestrian walk duration in ticks (1..255)

Ports:
- clk  input  1  system clock
- Reset_n  input  1  asynchronous, active-low reset
- OneHz  input  1  1 Hz square wave from divider, synchronous to clk
- EW_Sensor  input  1  side-road vehicle present, level
- Ped_Req  input  1  pedestrian button, level or pulse ≥1 clk
- Night_Mode  input  1  request flashing operation, level
- NS_Light  output  3  {Red,Yellow,Green}, one-hot or all-off
- EW_Light  output  3  {Red,Yellow,Green}, one-hot or all-off
- Walk  output  1  pedestrian walk lamp
- Ped_Ack  output  1  pedestrian request pending (button lamp)
- Seconds_Left  output  8  ticks remaining in current timed phase

Behaviour:
- Tick: one_d <= OneHz every clk. tick = OneHz & ~one_d, a single-clk pulse. one_d resets to 1, so no tick is generated at reset release while OneHz=1.
- All outputs are Moore decodes of the registered state, Seconds_Left and a flash bit. They change in the same clk edge as the state. No internal clock gating; all registers are on clk.
- States and durations:
  - ALL_RED: ALLRED_TIME
  - NS_GREEN: GREEN_MIN minimum
  - NS_YELLOW: YELLOW_TIME
  - CLEAR1: ALLRED_TIME
  - EW_GREEN: EW_GREEN
  - EW_YELLOW: YELLOW_TIME
  - PED_WALK: WALK_TIME
  - CLEAR2: ALLRED_TIME
  - FLASH: untimed
- Timer rules:
  - Seconds_Left is loaded with the phase duration on state entry and decrements on each tick.
  - A timed phase exits on the tick where Seconds_Left==1, so a phase lasts exactly N ticks.
  - Seconds_Left never underflows. In NS_GREEN it holds at 0 once the minimum has elapsed. In FLASH it is 0.
- Transitions, evaluated only on tick:
  - ALL_RED -> NS_GREEN.
  - NS_GREEN with Seconds_Left==0 (or ==1 on the expiring tick):
    - Night_Mode=1 -> FLASH.
    - Else ped_pend or ew_pend -> NS_YELLOW.
    - Else rest in NS_GREEN.
  - NS_YELLOW -> CLEAR1.
  - CLEAR1: ped_pend=1 -> PED_WALK. Else ew_pend=1 -> EW_GREEN. Else NS_GREEN (only if demand was withdrawn; the latches make this unreachable in practice).
  - EW_GREEN -> EW_YELLOW -> CLEAR2.
  - PED_WALK -> CLEAR2.
  - CLEAR2 -> NS_GREEN.
  - FLASH: Night_Mode=0 -> ALL_RED.
- Pedestrian priority: when both demands are pending, the pedestrian is served first. ew_pend stays set and is served on the next cycle through NS_GREEN.
- Demand latches, sampled every clk:
  - ew_pend is set by EW_Sensor and cleared on entry to EW_GREEN.
  - ped_pend is set by Ped_Req and cleared on entry to PED_WALK.
  - If set and clear occur in the same clk, clear wins.
  - Ped_Ack = ped_pend.
- Lamp decode:
  - NS_GREEN: NS=001, EW=100.
  - NS_YELLOW: NS=010, EW=100.
  - EW_GREEN: NS=100, EW=001.
  - EW_YELLOW: NS=100, EW=010.
  - ALL_RED, CLEAR1, CLEAR2: both 100.
  - PED_WALK: both 100, Walk=1. Walk=0 in all other states.
  - FLASH: a flash bit toggles each tick. NS=flash?010:000, EW=flash?100:000. The flash bit is cleared on FLASH entry, so the first FLASH second shows both lamps off.
- Reset (async assert, sync release):
  - State=ALL_RED, Seconds_Left=ALLRED_TIME.
  - NS_Light=100, EW_Light=100, Walk=0, Ped_Ack=0.
  - Latches=0, flash=0, one_d=1.
  - Reset mid-phase abandons the phase immediately and drops all pending demand.
- Invariant: at no clk are both roads non-red in a non-FLASH state. Assert in bench.

Test Plan:
- Reset release, OneHz ticking, no demand -> ALL_RED for 2 ticks, then NS_GREEN. Seconds_Left counts 10..1 then holds 0. Remains NS_GREEN indefinitely.
- EW_Sensor pulse 1 clk during tick 3 of NS_GREEN -> green runs the full 10 ticks, then NS_YELLOW 3, CLEAR1 2, EW_GREEN 8, EW_YELLOW 3, CLEAR2 2, back to NS_GREEN. ew_pend clears on EW_GREEN entry.
- Ped_Req and EW_Sensor both pending at NS_GREEN expiry -> PED_WALK (Walk=1 for 6 ticks, Ped_Ack drops at entry). Then CLEAR2, NS_GREEN 10, then the EW phase is served.
- Ped_Req asserted in the same clk as PED_WALK entry -> Ped_Ack stays 0 (clear wins). A Ped_Req one clk later sets Ped_Ack=1.
- Night_Mode=1 with NS_GREEN minimum elapsed -> FLASH. Over ticks: NS 000/010 and EW 000/100 alternate, starting off. Night_Mode=0 -> ALL_RED 2 ticks, then NS_GREEN.
- Reset_n pulsed low mid-EW_GREEN, asynchronous to clk -> outputs go to the reset values without waiting for a clk edge. No tick is emitted on release with OneHz=1.
